// File: rtl/sram_pkg.sv
// Shared definitions for the data-SRAM window: controller states, SRAM geometry,
// window region codes and the load/store opcodes used by the request decode and stall logic.
package sram_pkg;

  localparam int SRAM_AW = 18;

  localparam logic [3:0] REGION_LO = 4'h2;
  localparam logic [3:0] REGION_HI = 4'h3;

  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  function automatic logic in_window(input logic [15:0] addr);
    return (addr[15:12] == REGION_LO) || (addr[15:12] == REGION_HI);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits 32-bit window accesses into 16-bit async-SRAM cycles; ack at 1 + halves*(ACCESS_CYCLES+2).
// No backpressure: the core holds i_req until o_ack; latched request values are used throughout.
module sram_controller
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int SRAM_AW       = sram_pkg::SRAM_AW
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [12:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  output logic [31:0]        o_rdata,
  output logic               o_ack,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [15:0]        o_sram_dq_out,
  output logic               o_sram_dq_oe,
  input  logic [15:0]        i_sram_dq_in,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  state_t state, state_d;
  logic          half, half_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          we_q, we_d;
  logic [10:0]   widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    bmask_q, bmask_d;

  logic [31:0]        rdata_d;
  logic               ack_d;
  logic [SRAM_AW-1:0] addr_d;
  logic [15:0]        dq_out_d;
  logic               dq_oe_d, ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;
  logic [1:0]         mask_sel;

  // Byte offset within the word never reaches the 16-bit SRAM.
  logic addr_unused;
  assign addr_unused = ^i_addr[1:0];

  always_comb begin
    state_d  = state;
    half_d   = half;
    cnt_d    = cnt;
    we_d     = we_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    rdata_d  = o_rdata;
    ack_d    = 1'b0;
    addr_d   = o_sram_addr;
    dq_out_d = o_sram_dq_out;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    mask_sel = 2'b00;

    unique case (state)
      IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          widx_d  = i_addr[12:2];
          wdata_d = i_wdata;
          bmask_d = i_bmask;
          half_d  = i_we && (i_bmask[1:0] == 2'b00);
          cnt_d   = '0;
          state_d = (i_we && (i_bmask == 4'b0000)) ? DONE : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt == CNT_LAST) begin
          state_d = HOLD;
          if (!we_q) begin
            if (half) rdata_d[31:16] = i_sram_dq_in;
            else      rdata_d[15:0]  = i_sram_dq_in;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!half && (!we_q || (bmask_q[3:2] != 2'b00))) begin
          half_d  = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered, so they are decoded from the state being entered.
    mask_sel = half_d ? bmask_d[3:2] : bmask_d[1:0];
    if (state_d == SETUP || state_d == STROBE || state_d == HOLD) begin
      addr_d = SRAM_AW'({widx_d, half_d});
      ce_n_d = 1'b0;
      lb_n_d = we_d ? ~mask_sel[0] : 1'b0;
      ub_n_d = we_d ? ~mask_sel[1] : 1'b0;
      if (we_d) begin
        dq_out_d = half_d ? wdata_d[31:16] : wdata_d[15:0];
        dq_oe_d  = 1'b1;
      end
      oe_n_d = !((state_d == STROBE) && !we_d);
      we_n_d = !((state_d == STROBE) && we_d);
    end
    ack_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      half          <= 1'b0;
      cnt           <= '0;
      we_q          <= 1'b0;
      widx_q        <= '0;
      wdata_q       <= '0;
      bmask_q       <= '0;
      o_rdata       <= '0;
      o_ack         <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
      o_sram_dq_oe  <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_lb_n   <= 1'b1;
      o_sram_ub_n   <= 1'b1;
    end else begin
      state         <= state_d;
      half          <= half_d;
      cnt           <= cnt_d;
      we_q          <= we_d;
      widx_q        <= widx_d;
      wdata_q       <= wdata_d;
      bmask_q       <= bmask_d;
      o_rdata       <= rdata_d;
      o_ack         <= ack_d;
      o_sram_addr   <= addr_d;
      o_sram_dq_out <= dq_out_d;
      o_sram_dq_oe  <= dq_oe_d;
      o_sram_ce_n   <= ce_n_d;
      o_sram_oe_n   <= oe_n_d;
      o_sram_we_n   <= we_n_d;
      o_sram_lb_n   <= lb_n_d;
      o_sram_ub_n   <= ub_n_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench: two controllers (ACCESS_CYCLES 1 and 3), each with a pin-level SRAM
// and a word-level reference memory; a monitor checks every ack against queued expectations.
`timescale 1ns/1ps
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  typedef struct {
    int          start;
    int          lat;
    int          ce_cyc;
    int          we_cyc;
    int          oe_cyc;
    logic [31:0] rd;
  } exp_t;

  task automatic chk(input string nm, input int ac, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (AC=%0d): got %0h want %0h", nm, ac, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int AC = (g == 0) ? 1 : 3;

    logic        rst, req, we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    logic        ack;
    logic [17:0] sa;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

    sram_controller #(.ACCESS_CYCLES(AC), .SRAM_AW(18)) dut (
      .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .i_bmask(bmask), .o_rdata(rdata), .o_ack(ack),
      .o_sram_addr(sa), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe),
      .i_sram_dq_in(dq_in), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
      .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    // Pin-level asynchronous SRAM.
    logic [15:0] sram [4096];
    assign dq_in = (!ce_n && !oe_n) ? sram[sa[11:0]] : 16'h5A5A;
    always @(posedge clk) begin
      if (!ce_n && !we_n) begin
        if (!lb_n) sram[sa[11:0]][7:0]  <= dq_out[7:0];
        if (!ub_n) sram[sa[11:0]][15:8] <= dq_out[15:8];
      end
    end

    // Word-level reference model.
    logic [31:0] ref_mem [16];
    logic [31:0] last_rd = 32'h0;
    exp_t        q[$];
    bit          prev_keep = 1'b0;

    task automatic run(input logic w, input logic [12:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit keep, input bit drop);
      exp_t e;
      int   h;
      bit   got = 1'b0;
      we = w; addr = a; wdata = d; bmask = m; req = 1'b1;
      h = w ? (int'(m[1:0] != 2'b00) + int'(m[3:2] != 2'b00)) : 2;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        last_rd = ref_mem[a[5:2]];
      end
      e.start  = prev_keep ? cyc + 1 : cyc;
      e.lat    = 1 + h * (AC + 2);
      e.ce_cyc = h * (AC + 2);
      e.we_cyc = w ? h * AC : 0;
      e.oe_cyc = w ? 0 : 2 * AC;
      e.rd     = last_rd;
      q.push_back(e);
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (drop && k == 1) begin
          req = 1'b0; we = 1'($urandom); addr = 13'($urandom);
          wdata = $urandom; bmask = 4'($urandom);
        end
        if (ack) begin got = 1'b1; break; end
      end
      if (!got) begin
        chk("ack_timeout", AC, 0, 1);
        q.delete();
      end
      prev_keep = keep && !drop && got;
      if (!prev_keep) begin
        req = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    endtask

    task automatic check_reset(input string nm);
      chk({nm, "_ctl_n"}, AC, {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
      chk({nm, "_dq_oe"}, AC, dq_oe, 0);
      chk({nm, "_ack"}, AC, ack, 0);
      chk({nm, "_rdata"}, AC, rdata, 0);
      chk({nm, "_sram_addr"}, AC, sa, 0);
      chk({nm, "_dq_out"}, AC, dq_out, 0);
    endtask

    // Word 5 is rewritten with its own contents, so memory is consistent wherever the cut lands.
    task automatic reset_mid_write();
      bit seen = 1'b0;
      we = 1'b1; addr = 13'h0014; wdata = ref_mem[5]; bmask = 4'hF; req = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!we_n) begin seen = 1'b1; break; end
      end
      chk("reset_reached_strobe", AC, seen, 1);
      #1 rst = 1'b1;
      #1 check_reset("reset_mid_strobe");
      req = 1'b0;
      q.delete();
      last_rd = 32'h0;
      prev_keep = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    endtask

    initial begin : stim
      logic [12:0] a;
      logic [3:0]  m;
      bit          kp;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; bmask = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
      ref_mem[1] = 32'hDEADBEEF;
      for (int i = 0; i < 4096; i++)
        sram[i] <= (i < 32) ? (i[0] ? ref_mem[i/2][31:16] : ref_mem[i/2][15:0]) : 16'($urandom);
      repeat (3) @(negedge clk);
      check_reset("reset_state");
      rst = 1'b0;
      @(negedge clk);

      run(1'b0, 13'h0004, 32'h0, 4'hF, 1'b0, 1'b0);
      run(1'b1, 13'h0008, 32'h12345678, 4'hF, 1'b0, 1'b0);
      run(1'b1, 13'h000C, 32'h00AB0000, 4'b0100, 1'b0, 1'b0);
      run(1'b1, 13'h0010, 32'hCAFEF00D, 4'b0000, 1'b0, 1'b0);
      run(1'b1, 13'h0018, 32'hA1B2C3D4, 4'b1100, 1'b0, 1'b0);
      run(1'b1, 13'h001C, 32'h99887766, 4'b0011, 1'b0, 1'b0);
      run(1'b0, 13'h0008, 32'h0, 4'hF, 1'b1, 1'b0);
      run(1'b0, 13'h000C, 32'h0, 4'hF, 1'b1, 1'b0);
      run(1'b0, 13'h0018, 32'h0, 4'hF, 1'b0, 1'b0);
      reset_mid_write();

      for (int n = 0; n < 150; n++) begin
        a = {7'd0, 4'($urandom), 2'($urandom)};
        case ($urandom_range(0, 5))
          0:       m = 4'b0000;
          1:       m = 4'b0011;
          2:       m = 4'b1100;
          3:       m = 4'b1111;
          default: m = 4'($urandom);
        endcase
        kp = ($urandom_range(0, 2) == 0);
        run(1'($urandom), a, $urandom, m, kp, $urandom_range(0, 4) == 0);
      end

      for (int i = 0; i < 16; i++)
        run(1'b0, 13'(i * 4), 32'h0, 4'hF, i < 15, 1'b0);
      for (int i = 0; i < 32; i++)
        chk($sformatf("sram_image_%0d", i), AC, sram[i],
            i[0] ? ref_mem[i/2][31:16] : ref_mem[i/2][15:0]);
      done_cnt++;
    end

    initial begin : mon
      exp_t e;
      int ce_c = 0, we_c = 0, oe_c = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          ce_c = 0; we_c = 0; oe_c = 0;
        end else begin
          if (!ce_n) begin
            ce_c++;
            chk("sram_addr_upper_zero", AC, sa[17:12], 0);
          end
          if (!oe_n) begin
            oe_c++;
            chk("no_contention_dq_oe", AC, dq_oe, 0);
          end
          if (!we_n) begin
            we_c++;
            chk("write_drives_dq", AC, dq_oe, 1);
          end
          if (ack) begin
            if (q.size() == 0) begin
              chk("spurious_ack", AC, ack, 0);
            end else begin
              e = q.pop_front();
              chk("ack_latency", AC, cyc - e.start, e.lat);
              chk("ce_active_cycles", AC, ce_c, e.ce_cyc);
              chk("we_strobe_cycles", AC, we_c, e.we_cyc);
              chk("oe_strobe_cycles", AC, oe_c, e.oe_cyc);
              chk("rdata", AC, rdata, e.rd);
            end
            ce_c = 0; we_c = 0; oe_c = 0;
          end
        end
      end
    end
  end

  initial begin
    for (int t = 0; t < 60000 && done_cnt < 2; t++) @(negedge clk);
    if (done_cnt < 2) chk("global_timeout", 0, done_cnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
